pc_com_pilha: RTL and testbench
===============================

# pc_com_pilha

Parametrised program-counter register with a hardware return-address stack, the successor to the 16-bit PC register in the register bank. It supports sequential increment with a configurable step, absolute load, subroutine call (push + load) and return (pop). It also supports stall, and reports stack occupancy and a sticky stack error. It sits in the register bank in the PC slot and feeds instruction fetch.

## Interface
- LARGURA, 16, width of PC, data input and stack entries
- PROFUNDIDADE, 4, return-stack depth in entries (≥2, power of two not required)
- PASSO, 1, increment added per sequential step (mod 2^LARGURA)
- VETOR_RESET, 0, PC value loaded on reset

- Clock  in  1  rising-edge clock
- Reset_n  in  1  reset, asynchronous, active-low
- dadoEntrada  in  LARGURA  load/call target address
- habilita_escrita_local  in  1  load enable, ANDed with geral
- habilita_escrita_geral  in  1  bank-wide write enable
- incrementaPC  in  1  sequential advance request
- chamada  in  1  call: push return address, load dadoEntrada
- retorno  in  1  return: pop top of stack into PC
- congela  in  1  stall: hold all state
- limpa_erro  in  1  clear sticky erro_pilha
- dadoSaida  out  LARGURA  current PC (registered)
- ocupacao  out  $clog2(PROFUNDIDADE+1)  stack entries in use
- pilha_vazia  out  1  ocupacao == 0
- pilha_cheia  out  1  ocupacao == PROFUNDIDADE
- erro_pilha  out  1  sticky overflow/underflow flag

## Operation
- habilita = habilita_escrita_local & habilita_escrita_geral.
- One action per cycle, priority: congela > retorno > chamada > habilita > incrementaPC > hold.
- congela: PC, stack and ocupacao hold. limpa_erro is still honoured.
- retorno, stack not empty: dadoSaida ← top, ocupacao−1.
- retorno, stack empty: PC holds, erro_pilha ← 1.
- chamada, not full: push (dadoSaida + PASSO) mod 2^LARGURA, dadoSaida ← dadoEntrada, ocupacao+1.
- chamada, full: see Configuration. The PC load always happens.
- chamada does not require habilita.
- habilita: dadoSaida ← dadoEntrada.
- incrementaPC: dadoSaida ← (dadoSaida + PASSO) mod 2^LARGURA. Wraps silently, no flag.
- Simultaneous chamada+retorno: the return is performed and the call is ignored.
- erro_pilha: set on the cycle of the offending operation. Cleared by limpa_erro unless a new error occurs in the same cycle (set wins).
- Stack is LIFO. Only the top entry is observable, via retorno.

## Timing
- All state updates on the rising Clock edge; dadoSaida changes one cycle after the request is sampled.
- Back-to-back calls/returns are supported every cycle, with no bubbles.
- Flags are registered and consistent with ocupacao in the same cycle.
- Reset (asynchronous assert, any time including mid-operation):
  - dadoSaida = VETOR_RESET, ocupacao = 0, pilha_vazia = 1, pilha_cheia = 0, erro_pilha = 0.
  - Stack contents are don't-care.
- Deassertion of Reset_n is synchronised by the system; the first action is sampled on the first rising edge after deassertion.

## Configuration
- PC_PILHA_CIRCULAR_EN defined:
  - Call on a full stack overwrites the oldest entry (circular buffer).
  - ocupacao stays PROFUNDIDADE and erro_pilha is not set.
  - Underflow still sets erro_pilha.
- PC_PILHA_CIRCULAR_EN undefined:
  - Call on a full stack discards the push; stack contents and ocupacao are unchanged.
  - erro_pilha ← 1.

## Test plan
- Reset + increment: reset with VETOR_RESET=0x0100, PASSO=1, incrementaPC=1 for 3 cycles -> dadoSaida 0x0101, 0x0102, 0x0103; pilha_vazia=1.
- Load priority and stall: dadoSaida=0x0010, incrementaPC=1 with habilita=1 and dadoEntrada=0xABCD -> 0xABCD. Then congela=1 with incrementaPC=1 for 2 cycles -> stays 0xABCD.
- Call/return: from PC=0x0020, call 0x0200, increment twice, call 0x0300 -> stack holds 0x0021, 0x0203, ocupacao=2. Two returns -> PC 0x0203, then 0x0021, then pilha_vazia=1.
- Wrap and underflow: PC=0xFFFF, increment -> 0x0000, no flag. retorno on empty -> PC holds at 0x0000, erro_pilha=1. limpa_erro -> 0.
- Overflow (PROFUNDIDADE=4): 5 consecutive calls.
  - Without the macro: 5th call loads the PC, ocupacao=4, erro_pilha=1; 4 returns yield the first four return addresses.
  - With the macro: erro_pilha=0; 4 returns yield calls 5..2's return addresses.
- Async reset mid-call: assert Reset_n low between edges with ocupacao=3 -> outputs immediately become VETOR_RESET, 0, vazia=1, erro=0.

Source files
------------

// File: rtl/pc_com_pilha.sv
// Program counter with a hardware return-address stack (call/return/stall/load/increment).
// Define PC_PILHA_CIRCULAR_EN to make a call on a full stack overwrite the oldest entry.
module pc_com_pilha #(
   parameter int                 LARGURA      = 16,
   parameter int                 PROFUNDIDADE = 4,
   parameter int                 PASSO        = 1,
   parameter logic [LARGURA-1:0] VETOR_RESET  = '0
) (
   input  logic                              Clock,
   input  logic                              Reset_n,
   input  logic [LARGURA-1:0]                dadoEntrada,
   input  logic                              habilita_escrita_local,
   input  logic                              habilita_escrita_geral,
   input  logic                              incrementaPC,
   input  logic                              chamada,
   input  logic                              retorno,
   input  logic                              congela,
   input  logic                              limpa_erro,
   output logic [LARGURA-1:0]                dadoSaida,
   output logic [$clog2(PROFUNDIDADE+1)-1:0] ocupacao,
   output logic                              pilha_vazia,
   output logic                              pilha_cheia,
   output logic                              erro_pilha
);

   localparam int IW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
   localparam int OW = $clog2(PROFUNDIDADE + 1);

   localparam logic [IW-1:0]      IDX_ULTIMO = IW'(PROFUNDIDADE - 1);
   localparam logic [IW-1:0]      IDX_UM     = IW'(1);
   localparam logic [OW-1:0]      OCUP_MAX   = OW'(PROFUNDIDADE);
   localparam logic [OW-1:0]      OCUP_UM    = OW'(1);
   localparam logic [LARGURA-1:0] INCR       = LARGURA'(PASSO);

   // Stack storage carries no reset: entries are only read below the occupancy count.
   logic [LARGURA-1:0] pilha [PROFUNDIDADE];

   // topo is the next slot to write; the most recent entry sits one slot below it.
   logic [IW-1:0]      topo;
   logic [IW-1:0]      topo_seg;
   logic [IW-1:0]      topo_ant;

   logic               habilita;
   logic [LARGURA-1:0] end_retorno;
   logic [LARGURA-1:0] pc_prox;
   logic [OW-1:0]      ocup_prox;
   logic [IW-1:0]      topo_prox;
   logic               empilha;
   logic               erro_novo;
   logic               erro_prox;

   assign habilita    = habilita_escrita_local & habilita_escrita_geral;
   assign end_retorno = dadoSaida + INCR;
   assign topo_seg    = (topo == IDX_ULTIMO) ? '0 : topo + IDX_UM;
   assign topo_ant    = (topo == '0) ? IDX_ULTIMO : topo - IDX_UM;

   always_comb begin
      pc_prox   = dadoSaida;
      ocup_prox = ocupacao;
      topo_prox = topo;
      empilha   = 1'b0;
      erro_novo = 1'b0;

      if (!congela) begin
         if (retorno) begin
            if (!pilha_vazia) begin
               pc_prox   = pilha[topo_ant];
               topo_prox = topo_ant;
               ocup_prox = ocupacao - OCUP_UM;
            end else begin
               erro_novo = 1'b1;
            end
         end else if (chamada) begin
            pc_prox = dadoEntrada;
            if (!pilha_cheia) begin
               empilha   = 1'b1;
               topo_prox = topo_seg;
               ocup_prox = ocupacao + OCUP_UM;
            end else begin
`ifdef PC_PILHA_CIRCULAR_EN
               // When full, topo already points at the oldest entry, so it is overwritten.
               empilha   = 1'b1;
               topo_prox = topo_seg;
`else
               erro_novo = 1'b1;
`endif
            end
         end else if (habilita) begin
            pc_prox = dadoEntrada;
         end else if (incrementaPC) begin
            pc_prox = dadoSaida + INCR;
         end
      end

      // A fresh error in the same cycle beats the clear.
      erro_prox = erro_novo | (erro_pilha & ~limpa_erro);
   end

   always_ff @(posedge Clock) begin
      if (empilha) begin
         pilha[topo] <= end_retorno;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         dadoSaida   <= VETOR_RESET;
         topo        <= '0;
         ocupacao    <= '0;
         pilha_vazia <= 1'b1;
         pilha_cheia <= 1'b0;
         erro_pilha  <= 1'b0;
      end else begin
         dadoSaida   <= pc_prox;
         topo        <= topo_prox;
         ocupacao    <= ocup_prox;
         pilha_vazia <= (ocup_prox == '0);
         pilha_cheia <= (ocup_prox == OCUP_MAX);
         erro_pilha  <= erro_prox;
      end
   end

endmodule

// File: tb/tb_pc_com_pilha.sv
// Bench for pc_com_pilha: directed vector table, overflow/reset sequences and a random run
// against a queue-based reference model.
module tb_pc_com_pilha;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic [15:0] dadoEntrada;
   logic        habilita_escrita_local;
   logic        habilita_escrita_geral;
   logic        incrementaPC;
   logic        chamada;
   logic        retorno;
   logic        congela;
   logic        limpa_erro;
   logic [15:0] dadoSaida;
   logic [2:0]  ocupacao;
   logic        pilha_vazia;
   logic        pilha_cheia;
   logic        erro_pilha;

   always #5 Clock = ~Clock;

   pc_com_pilha #(
      .LARGURA(16), .PROFUNDIDADE(4), .PASSO(1), .VETOR_RESET(16'h0100)
   ) dut (
      .Clock(Clock), .Reset_n(Reset_n), .dadoEntrada(dadoEntrada),
      .habilita_escrita_local(habilita_escrita_local),
      .habilita_escrita_geral(habilita_escrita_geral),
      .incrementaPC(incrementaPC), .chamada(chamada), .retorno(retorno),
      .congela(congela), .limpa_erro(limpa_erro), .dadoSaida(dadoSaida),
      .ocupacao(ocupacao), .pilha_vazia(pilha_vazia), .pilha_cheia(pilha_cheia),
      .erro_pilha(erro_pilha)
   );

   // Control bits in the table: {hab_local, hab_geral, inc, chamada, retorno, congela, limpa}
   typedef struct {
      logic [15:0] din;
      logic [6:0]  ctl;
      logic [15:0] pc;
      int          ocup;
      logic        erro;
   } vec_t;

   vec_t        tab[$];
   logic [21:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   // Reference model state
   logic [15:0] m_pc;
   logic [15:0] m_stk[$];
   logic        m_erro;

   function automatic vec_t mk(logic [15:0] din, logic [6:0] ctl, logic [15:0] pc,
                               int ocup, logic erro);
      vec_t v;
      v.din = din; v.ctl = ctl; v.pc = pc; v.ocup = ocup; v.erro = erro;
      return v;
   endfunction

   function automatic logic [21:0] pack(logic [15:0] pc, int ocup, logic erro);
      return {pc, 3'(ocup), (ocup == 0), (ocup == 4), erro};
   endfunction

   function automatic logic [21:0] dut_out();
      return {dadoSaida, ocupacao, pilha_vazia, pilha_cheia, erro_pilha};
   endfunction

   task automatic compare(input string name, input logic [21:0] got, input logic [21:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got pc=%h ocup=%0d vazia=%b cheia=%b erro=%b, want pc=%h ocup=%0d vazia=%b cheia=%b erro=%b",
                  name, got[21:6], got[5:3], got[2], got[1], got[0],
                  expv[21:6], expv[5:3], expv[2], expv[1], expv[0]);
      end
   endtask

   task automatic drive(input logic [15:0] din, input logic [6:0] ctl);
      dadoEntrada            = din;
      habilita_escrita_local = ctl[6];
      habilita_escrita_geral = ctl[5];
      incrementaPC           = ctl[4];
      chamada                = ctl[3];
      retorno                = ctl[2];
      congela                = ctl[1];
      limpa_erro             = ctl[0];
   endtask

   // Expectation is queued with the stimulus and retired one edge later.
   task automatic step(input string name, input logic [15:0] din, input logic [6:0] ctl,
                       input logic [21:0] expv);
      logic [21:0] e;
      drive(din, ctl);
      exp_q.push_back(expv);
      @(posedge Clock);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard queue empty", name);
      end else begin
         e = exp_q.pop_front();
         compare(name, dut_out(), e);
      end
   endtask

   // Independent model: advances m_* for one cycle and returns the expected outputs.
   function automatic logic [21:0] model(input logic [15:0] din, input logic [6:0] ctl);
      logic en;
      en = 1'b0;
      if (!ctl[1]) begin
         if (ctl[2]) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else en = 1'b1;
         end else if (ctl[3]) begin
            if (m_stk.size() < 4) m_stk.push_back(m_pc + 16'd1);
            else begin
`ifdef PC_PILHA_CIRCULAR_EN
               void'(m_stk.pop_front());
               m_stk.push_back(m_pc + 16'd1);
`else
               en = 1'b1;
`endif
            end
            m_pc = din;
         end else if (ctl[6] && ctl[5]) begin
            m_pc = din;
         end else if (ctl[4]) begin
            m_pc = m_pc + 16'd1;
         end
      end
      m_erro = en | (m_erro & ~ctl[0]);
      return pack(m_pc, m_stk.size(), m_erro);
   endfunction

   task automatic do_reset();
      Reset_n = 1'b0;
      drive(16'h0000, 7'b0000000);
      repeat (2) @(posedge Clock);
      #1;
      Reset_n = 1'b1;
      m_pc = 16'h0100;
      m_stk.delete();
      m_erro = 1'b0;
   endtask

   initial begin
      logic [15:0] ra [5];
      logic [6:0]  c;
      logic [15:0] d;

      tab.push_back(mk(16'h0000, 7'b0010000, 16'h0101, 0, 0));
      tab.push_back(mk(16'h0000, 7'b0010000, 16'h0102, 0, 0));
      tab.push_back(mk(16'h0000, 7'b0010000, 16'h0103, 0, 0));
      tab.push_back(mk(16'h0010, 7'b1100000, 16'h0010, 0, 0));
      tab.push_back(mk(16'hABCD, 7'b1110000, 16'hABCD, 0, 0));
      tab.push_back(mk(16'h0000, 7'b0010010, 16'hABCD, 0, 0));
      tab.push_back(mk(16'h0000, 7'b0010010, 16'hABCD, 0, 0));
      tab.push_back(mk(16'h0020, 7'b1100000, 16'h0020, 0, 0));
      tab.push_back(mk(16'h0200, 7'b0001000, 16'h0200, 1, 0));
      tab.push_back(mk(16'h0000, 7'b0010000, 16'h0201, 1, 0));
      tab.push_back(mk(16'h0000, 7'b0010000, 16'h0202, 1, 0));
      tab.push_back(mk(16'h0300, 7'b0001000, 16'h0300, 2, 0));
      tab.push_back(mk(16'h0000, 7'b0000100, 16'h0203, 1, 0));
      tab.push_back(mk(16'h0000, 7'b0000100, 16'h0021, 0, 0));
      tab.push_back(mk(16'hFFFF, 7'b1100000, 16'hFFFF, 0, 0));
      tab.push_back(mk(16'h0000, 7'b0010000, 16'h0000, 0, 0));
      tab.push_back(mk(16'h0000, 7'b0000100, 16'h0000, 0, 1));
      tab.push_back(mk(16'h0000, 7'b0000001, 16'h0000, 0, 0));
      tab.push_back(mk(16'h7777, 7'b0001100, 16'h0000, 0, 1));
      tab.push_back(mk(16'h0000, 7'b0000101, 16'h0000, 0, 1));
      tab.push_back(mk(16'h4444, 7'b0001011, 16'h0000, 0, 0));
      tab.push_back(mk(16'h1000, 7'b0001000, 16'h1000, 1, 0));
      tab.push_back(mk(16'h2000, 7'b0001100, 16'h0001, 0, 0));
      tab.push_back(mk(16'h5555, 7'b1010000, 16'h0002, 0, 0));
      tab.push_back(mk(16'h5555, 7'b0110000, 16'h0003, 0, 0));
      tab.push_back(mk(16'h3000, 7'b1101000, 16'h3000, 1, 0));
      tab.push_back(mk(16'h0000, 7'b0000110, 16'h3000, 1, 0));
      tab.push_back(mk(16'h0000, 7'b0000100, 16'h0004, 0, 0));

      do_reset();
      compare("reset_state", dut_out(), pack(16'h0100, 0, 0));

      foreach (tab[i]) begin
         step($sformatf("vec%0d", i), tab[i].din, tab[i].ctl,
              pack(tab[i].pc, tab[i].ocup, tab[i].erro));
      end

      // Five calls on a depth-4 stack
      step("ovf_load", 16'h0A00, 7'b1100000, pack(16'h0A00, 0, 0));
      ra[0] = 16'h0A01;
      for (int i = 0; i < 5; i++) begin
         d = 16'((i + 1) * 16'h1000);
         if (i < 4) ra[i + 1] = d + 16'd1;
`ifdef PC_PILHA_CIRCULAR_EN
         step($sformatf("ovf_call%0d", i), d, 7'b0001000, pack(d, (i < 4) ? i + 1 : 4, 1'b0));
`else
         step($sformatf("ovf_call%0d", i), d, 7'b0001000, pack(d, (i < 4) ? i + 1 : 4, i == 4));
`endif
      end
      for (int i = 0; i < 4; i++) begin
`ifdef PC_PILHA_CIRCULAR_EN
         step($sformatf("ovf_ret%0d", i), 16'h0000, 7'b0000100, pack(ra[4 - i], 3 - i, 1'b0));
`else
         step($sformatf("ovf_ret%0d", i), 16'h0000, 7'b0000100, pack(ra[3 - i], 3 - i, 1'b1));
`endif
      end
`ifdef PC_PILHA_CIRCULAR_EN
      step("ovf_underflow", 16'h0000, 7'b0000100, pack(ra[1], 0, 1'b1));
      step("ovf_clear", 16'h0000, 7'b0000001, pack(ra[1], 0, 1'b0));
`else
      step("ovf_underflow", 16'h0000, 7'b0000100, pack(ra[0], 0, 1'b1));
      step("ovf_clear", 16'h0000, 7'b0000001, pack(ra[0], 0, 1'b0));
`endif

      // Asynchronous reset between edges with three entries stacked
      step("ar_call0", 16'h0B00, 7'b0001000, pack(16'h0B00, 1, 0));
      step("ar_call1", 16'h0C00, 7'b0001000, pack(16'h0C00, 2, 0));
      step("ar_call2", 16'h0D00, 7'b0001100 & 7'b0001000, pack(16'h0D00, 3, 0));
      drive(16'h0E00, 7'b0001000);
      #3;
      Reset_n = 1'b0;
      #1;
      compare("async_reset_immediate", dut_out(), pack(16'h0100, 0, 0));
      @(posedge Clock);
      #1;
      compare("async_reset_held", dut_out(), pack(16'h0100, 0, 0));
      Reset_n = 1'b1;
      m_pc = 16'h0100;
      m_stk.delete();
      m_erro = 1'b0;

      // Random traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         c[6] = ($urandom_range(0, 3) == 0);
         c[5] = ($urandom_range(0, 3) != 0);
         c[4] = ($urandom_range(0, 1) == 0);
         c[3] = ($urandom_range(0, 3) == 0);
         c[2] = ($urandom_range(0, 3) == 0);
         c[1] = ($urandom_range(0, 9) == 0);
         c[0] = ($urandom_range(0, 7) == 0);
         d = 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 15) == 0) d = 16'hFFFF;
         step($sformatf("rand%0d", n), d, c, model(d, c));
      end

      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
